pwm_multi_shadow: RTL
=====================

// Module: pwm_multi_shadow
// PURPOSE
//  N-bit, CH-channel PWM generator sharing one period counter. Successor to the single-channel pwmN.
//  Adds edge/centre-aligned modes, per-channel output inversion and shadowed (glitch-free) period/duty
//  updates applied only at a period boundary. Drives motor/LED/servo outputs from a CPU-written register bank.
// PARAMETERS
//  N    8       counter / period / duty width (bits)
//  CH   4       number of PWM channels
//  INV  {CH{0}} per-channel output inversion mask (bit i = 1 -> pwm[i] active-low)
// PORTS
//  clk          in   1     system clock, all logic on rising edge
//  clr          in   1     asynchronous, active-low reset
//  en           in   1     run enable; 0 = counter held at 0, outputs inactive
//  load         in   1     1-cycle strobe: capture period/duty/center into shadow regs
//  center       in   1     mode for next load: 0 = edge-aligned, 1 = centre-aligned
//  period       in   N     period value for next load (P)
//  duty         in   CH*N  duty values, channel i = duty[i*N +: N] (D_i)
//  pwm          out  CH    registered PWM outputs
//  cycle_start  out  1     registered 1-clk pulse at first clock of each PWM period
//  pending      out  1     shadow holds values not yet transferred to active regs
// BEHAVIOUR
//  Reset (clr=0, async): cnt=0, dir=up, shadow+active P/D/mode=0, pending=0, pwm=INV, cycle_start=0.
//  Shadow: load=1 -> shadow<=inputs, pending<=1 (later load overwrites; last one wins).
//  Transfer: active<=shadow, pending<=0 on an edge where en=0, or en=1 and next cnt==0 (boundary).
//   load on a boundary edge: captured to shadow, applied at the FOLLOWING boundary; pending stays 1.
//  Edge mode (en=1): cnt <= (cnt>=P) ? 0 : cnt+1. Period = P+1 clocks. Boundary when cnt>=P.
//  Centre mode (en=1): up/down; up: cnt==P -> dir=down, cnt=P-1; down: cnt==1 -> cnt=0 (boundary),
//   cnt==0 -> dir=up, cnt=1. Period = 2P clocks (P>=1). P==0: cnt stays 0, every clock a boundary.
//   Mode change at transfer: cnt restarts at 0, dir=up.
//  Compare (both modes): pwm[i] <= en ? ((cnt < D_i) ^ INV[i]) : INV[i]. One clock after cnt value.
//   Edge: high clocks/period = min(D_i, P+1); D_i=0 -> never high; D_i>P -> constant high.
//   Centre: high clocks = 2*D_i-1 for 1<=D_i<=P, symmetric about cnt=0; D_i>P -> constant high.
//  cycle_start <= en & (cnt==0) & (dir==up or centre P==0); aligned with pwm of that cnt.
//  en=0: cnt<=0, dir<=up, pwm<=INV, cycle_start<=0. en rise: first pwm edge reflects cnt=0,
//   i.e. first period begins the edge en is first sampled 1, using freshly transferred values.
//  All arithmetic unsigned N-bit; cnt never exceeds max(P_active, 0); no wrap past 2^N-1.
//  Async reset mid-period: outputs go inactive immediately; restart from cnt=0 after release.
// TESTING
//  T1 edge: load P=9, D0=3,D1=0,D2=10,D3=255, en=1 -> period 10 clks; pwm0 high 3, pwm1 low, pwm2/3 high.
//  T2 centre: load center=1 P=4 D0=2 -> period 8 clks, pwm0 high 3 clks centred on cnt=0, cycle_start every 8.
//  T3 shadow: mid-period load D0=7 (P=9) -> pending=1, pwm0 keeps 3-clk width until next cycle_start, then 7; pending=0.
//  T4 boundary load: load asserted on edge where cnt==P -> new values appear one full period later.
//  T5 INV=4'b0010, en=0 -> pwm=4'b0010; clr pulse low mid-period -> pwm=INV, cnt=0 instantly, restart clean.
//  T6 sweep: P=255, D0 0..255 each 256 clks (as pwmN bench) -> high count == D0 every period.

Source files
------------

// File: rtl/pwm_multi_shadow.sv
// Multi-channel PWM generator sharing one period counter, with edge/centre-aligned modes,
// per-channel output inversion and shadowed period/duty/mode updates applied at period boundaries.
module pwm_multi_shadow #(
    parameter int unsigned   N   = 8,
    parameter int unsigned   CH  = 4,
    parameter logic [CH-1:0] INV = '0
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
    input  logic            load,
    input  logic            center,
    input  logic [N-1:0]    period,
    input  logic [CH*N-1:0] duty,
    output logic [CH-1:0]   pwm,
    output logic            cycle_start,
    output logic            pending
);

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    dir_t            dir;
    dir_t            dir_nxt;
    logic [N-1:0]    cnt;
    logic [N-1:0]    cnt_nxt;
    logic            boundary;
    logic [CH-1:0]   cmp;

    logic [N-1:0]    sh_p;
    logic [N-1:0]    act_p;
    logic [CH*N-1:0] sh_d;
    logic [CH*N-1:0] act_d;
    logic            sh_c;
    logic            act_c;

    // Next counter state for the active mode. Every arrival at cnt==0 is made with dir=UP,
    // so cnt==0 && UP marks the first clock of a period in both modes.
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        cnt_nxt = '0;
        dir_nxt = UP;
        if (!act_c) begin
            if (cnt < act_p) cnt_nxt = cnt + 1'b1;
        end else if (act_p != '0) begin
            if (dir == UP) begin
                if (cnt >= act_p) begin
                    cnt_nxt = act_p - 1'b1;
                    dir_nxt = (act_p == N'(1)) ? UP : DOWN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (cnt > N'(1)) begin
                cnt_nxt = cnt - 1'b1;
                dir_nxt = DOWN;
            end else if (cnt == '0) begin
                cnt_nxt = N'(1);
            end
        end
    end

    assign boundary = (cnt_nxt == '0);

    always_comb begin
        cmp = '0;
        for (int i = 0; i < int'(CH); i++) begin
            cmp[i] = (cnt < act_d[i*N +: N]);
        end
    end

    // NOTE: shadow and active registers are plain flops, so they are reset like any other state;
    // sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt         <= '0;
            dir         <= UP;
            sh_p        <= '0;
            sh_d        <= '0;
            sh_c        <= 1'b0;
            act_p       <= '0;
            act_d       <= '0;
            act_c       <= 1'b0;
            pending     <= 1'b0;
            pwm         <= INV;
            cycle_start <= 1'b0;
        end else begin
            if (load) begin
                sh_p <= period;
                sh_d <= duty;
                sh_c <= center;
            end

            // Transfer uses the shadow as it was before this edge; a simultaneous load waits a period.
            if (!en || boundary) begin
                act_p <= sh_p;
                act_d <= sh_d;
                act_c <= sh_c;
            end

            if (load)                pending <= 1'b1;
            else if (!en || boundary) pending <= 1'b0;

            if (en) begin
                cnt         <= cnt_nxt;
                dir         <= dir_nxt;
                cycle_start <= (cnt == '0) && (dir == UP);
                pwm         <= cmp ^ INV;
            end else begin
                cnt         <= '0;
                dir         <= UP;
                cycle_start <= 1'b0;
                pwm         <= INV;
            end
        end
    end

endmodule
